somador_serial_param: RTL and testbench
=======================================

// Module: somador_serial_param
// PURPOSE
// - Parametrised, multi-cycle digit-serial adder/subtractor with a signed-overflow flag (f) and carry out.
// - Processes CHUNK bits per clock, LSB chunk first; carry ripples through a register between chunks.
// - Optional saturation on signed overflow.
// - valid/ready handshake on input and output; sits between operand sources and the accumulator datapath.
// PARAMETERS
// - WIDTH   16  operand/result width; WIDTH % CHUNK == 0 required, elaboration error otherwise
// - CHUNK   4   bits summed per cycle; NCHUNK = WIDTH/CHUNK
// - SAT_EN  1   1: sat input honoured; 0: sat ignored, result always wraps
// PORTS
// - clk        in   1      clock, rising edge
// - rst        in   1      asynchronous reset, active-high
// - in_valid   in   1      operands valid
// - in_ready   out  1      block can accept operands
// - a          in   WIDTH  operand A, two's complement
// - b          in   WIDTH  operand B, two's complement
// - sub        in   1      0: a+b, 1: a-b; sampled with operands
// - sat        in   1      1: saturate on signed overflow; sampled with operands
// - out_valid  out  1      result valid
// - out_ready  in   1      consumer takes result
// - soma       out  WIDTH  result
// - f          out  1      signed overflow of the raw (unsaturated) operation
// - cout       out  1      carry out of MSB (for sub: 1 = no borrow)
// BEHAVIOUR
// - Reset (async): state=IDLE, chunk counter=0, carry reg=0, soma=0, f=0, cout=0, out_valid=0.
//   in_ready=0 while rst high.
// - FSM IDLE -> CALC -> DONE -> IDLE.
// - IDLE: in_ready=1. On in_valid&&in_ready:
//   - latch a, bx=(sub ? ~b : b), carry=sub, sat_q=sat&SAT_EN.
//   - counter=0; go CALC.
// - CALC: in_ready=0. Each cycle, chunk k of soma = a[k]+bx[k]+carry; carry reg <= chunk carry; k++.
//   - After chunk NCHUNK-1: cout <= carry, f <= (a[MSB]==bx[MSB]) && (raw[MSB]!=a[MSB]); go DONE.
// - DONE: out_valid=1; soma/f/cout held stable until out_valid&&out_ready; then IDLE, out_valid=0.
// - Latency: accept at edge E; out_valid high after edge E+NCHUNK. Min spacing between accepts: NCHUNK+2 cycles.
// - Saturation (sat_q=1 and f=1):
//   - soma = a[MSB] ? {1'b1,{WIDTH-1{1'b0}}} : {1'b0,{WIDTH-1{1'b1}}}.
//   - f and cout still report the raw result. No effect when f=0.
// - in_valid while not IDLE is ignored; operands are not queued.
// - a, b, sub, sat changing after accept have no effect.
// - Wrap-around: unsigned overflow is not an error; soma wraps mod 2^WIDTH and cout=1.
// - Reset mid-CALC or mid-DONE aborts the operation; the result is lost, and no out_valid pulse follows.
// - out_ready with out_valid=0 has no effect.
// STRUCTURE
// - Package somador_pkg:
//   - typedef enum logic [1:0] {IDLE, CALC, DONE} somador_state_t.
//   - function overflow_f(a_msb, b_msb, s_msb).
//   - function sat_value(WIDTH, neg).
// - Sub-module somador_chunk #(CHUNK):
//   - combinational CHUNK-bit ripple slice; ports a, b, cin, s, cout.
//   - bitwise sum/carry equations of the 8-bit adder generation.
// - Top: FSM, counter of $clog2(NCHUNK+1) bits, operand/result registers, one somador_chunk instance.
// TESTING (WIDTH=16, CHUNK=4)
// - Overflow, wrap: a=16'h7FFF, b=16'h0001, sub=0, sat=0
//   -> soma=16'h8000, f=1, cout=0; out_valid exactly 4 cycles after accept.
// - Overflow, saturate: same operands, sat=1 -> soma=16'h7FFF, f=1, cout=0.
// - Subtract, saturate: a=16'h8000, b=16'h0001, sub=1, sat=1 -> soma=16'h8000 (raw 16'h7FFF), f=1, cout=1.
// - Unsigned wrap: a=16'hFFFF, b=16'h0001, sub=0 -> soma=16'h0000, f=0, cout=1.
// - Backpressure: hold out_ready=0 for 5 cycles and drive in_valid=1 with new operands
//   -> soma/f/cout stable, in_ready=0, new operands ignored.
//   - Release out_ready -> IDLE next cycle; the following op is correct.
// - Reset in CALC after 2 chunks -> out_valid=0, soma=0 immediately.
//   - Next op: a=16'h1234, b=16'h4321 -> soma=16'h5555, f=0, cout=0.

Source files
------------

// File: rtl/somador_pkg.sv
// Shared types and helpers for the digit-serial adder/subtractor.
//   somador_state_t : control FSM states (IDLE -> CALC -> DONE -> IDLE)
//   overflow_f      : two's-complement overflow from the operand and sum MSBs
//   sat_value       : saturation word for a given width, most negative or
//                     most positive depending on 'neg'
package somador_pkg;

  typedef enum logic [1:0] {IDLE, CALC, DONE} somador_state_t;

  // Widest word sat_value can build; callers truncate to their own width.
  localparam int SAT_MAX_WIDTH = 64;

  // Overflow occurs when both addends have the same sign and the sum does not.
  function automatic logic overflow_f(input logic a_msb, input logic b_msb,
                                      input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

  // neg=1 -> {1, 0...0}, neg=0 -> {0, 1...1}, placed in the low 'width' bits.
  function automatic logic [SAT_MAX_WIDTH-1:0] sat_value(input int width,
                                                         input logic neg);
    logic [SAT_MAX_WIDTH-1:0] v;
    v = '0;
    for (int i = 0; i < SAT_MAX_WIDTH; i++) begin
      if (i < width - 1) v[i] = ~neg;
      else if (i == width - 1) v[i] = neg;
    end
    return v;
  endfunction

endpackage

// File: rtl/somador_chunk.sv
// Combinational CHUNK-bit ripple-carry slice.
//   a, b : CHUNK-bit addends
//   cin  : carry in
//   s    : CHUNK-bit sum
//   cout : carry out of the slice MSB
module somador_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout
);

  logic [CHUNK:0] c;

  assign c[0] = cin;

  generate
    for (genvar gi = 0; gi < CHUNK; gi++) begin : g_bit
      assign s[gi]    = a[gi] ^ b[gi] ^ c[gi];
      assign c[gi+1]  = (a[gi] & b[gi]) | (c[gi] & (a[gi] ^ b[gi]));
    end
  endgenerate

  assign cout = c[CHUNK];

endmodule

// File: rtl/somador_serial_param.sv
// Digit-serial adder/subtractor: CHUNK bits per clock, LSB chunk first, with
// a registered carry between chunks, signed-overflow flag and optional
// saturation.
//   clk, rst              : clock, asynchronous active-high reset
//   in_valid/in_ready     : operand handshake (a, b, sub, sat sampled on accept)
//   out_valid/out_ready   : result handshake (soma, f, cout held until taken)
//   soma                  : result (saturated when enabled and f=1)
//   f                     : signed overflow of the raw operation
//   cout                  : carry out of the MSB (for subtraction 1 = no borrow)
module somador_serial_param
  import somador_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int CHUNK  = 4,
  parameter int SAT_EN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] soma,
  output logic             f,
  output logic             cout
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = $clog2(NCHUNK + 1);
  localparam logic [CW-1:0] LAST_CHUNK = CW'(NCHUNK - 1);

  generate
    if (WIDTH % CHUNK != 0) begin : g_bad_chunk
      $error("somador_serial_param: WIDTH must be a multiple of CHUNK");
    end
    if (WIDTH > SAT_MAX_WIDTH) begin : g_bad_width
      $error("somador_serial_param: WIDTH exceeds sat_value range");
    end
  endgenerate

  somador_state_t   state_reg;
  logic [CW-1:0]    count_reg;
  logic [WIDTH-1:0] a_reg;        // shifts right one chunk per CALC cycle
  logic [WIDTH-1:0] bx_reg;       // b or ~b, shifted alongside a_reg
  logic             a_msb_reg;    // sign bits kept aside, the shifters lose them
  logic             bx_msb_reg;
  logic             carry_reg;
  logic             sat_reg;
  logic [WIDTH-1:0] soma_reg;     // result shifts in from the top
  logic             f_reg;
  logic             cout_reg;
  logic             out_valid_reg;

  logic [CHUNK-1:0] chunk_s;
  logic             chunk_c;
  logic [WIDTH-1:0] raw_next;
  logic             ovf_next;

  somador_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a    (a_reg[CHUNK-1:0]),
    .b    (bx_reg[CHUNK-1:0]),
    .cin  (carry_reg),
    .s    (chunk_s),
    .cout (chunk_c)
  );

  // Full raw result as it will look once the current chunk is shifted in.
  assign raw_next = WIDTH'({chunk_s, soma_reg} >> CHUNK);
  assign ovf_next = overflow_f(a_msb_reg, bx_msb_reg, chunk_s[CHUNK-1]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      count_reg     <= '0;
      a_reg         <= '0;
      bx_reg        <= '0;
      a_msb_reg     <= 1'b0;
      bx_msb_reg    <= 1'b0;
      carry_reg     <= 1'b0;
      sat_reg       <= 1'b0;
      soma_reg      <= '0;
      f_reg         <= 1'b0;
      cout_reg      <= 1'b0;
      out_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            a_reg      <= a;
            bx_reg     <= sub ? ~b : b;
            a_msb_reg  <= a[WIDTH-1];
            bx_msb_reg <= sub ? ~b[WIDTH-1] : b[WIDTH-1];
            carry_reg  <= sub;
            sat_reg    <= sat & (SAT_EN != 0);
            count_reg  <= '0;
            state_reg  <= CALC;
          end
        end
        CALC: begin
          a_reg     <= a_reg >> CHUNK;
          bx_reg    <= bx_reg >> CHUNK;
          carry_reg <= chunk_c;
          count_reg <= count_reg + 1'b1;
          if (count_reg == LAST_CHUNK) begin
            cout_reg      <= chunk_c;
            f_reg         <= ovf_next;
            soma_reg      <= (sat_reg && ovf_next) ?
                             WIDTH'(sat_value(WIDTH, a_msb_reg)) : raw_next;
            out_valid_reg <= 1'b1;
            state_reg     <= DONE;
          end else begin
            soma_reg <= raw_next;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Kept combinational so it drops in the same instant rst rises.
  assign in_ready  = (state_reg == IDLE) && !rst;
  assign out_valid = out_valid_reg;
  assign soma      = soma_reg;
  assign f         = f_reg;
  assign cout      = cout_reg;

endmodule

// File: tb/tb_somador_serial_param.sv
module tb_somador_serial_param;

  localparam int WIDTH  = 16;
  localparam int CHUNK  = 4;
  localparam int NCHUNK = WIDTH / CHUNK;

  typedef struct {
    logic [WIDTH-1:0] soma;
    logic             f;
    logic             cout;
  } exp_t;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             sat;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] soma;
  logic             f;
  logic             cout;

  exp_t sb[$];
  int   checks;
  int   errors;
  int   n_out;

  somador_serial_param #(.WIDTH(WIDTH), .CHUNK(CHUNK), .SAT_EN(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .sat       (sat),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .soma      (soma),
    .f         (f),
    .cout      (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: a transfer happens on the next rising edge whenever both
  // handshake signals are high at the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got soma=%0h with empty scoreboard", soma);
        end else begin
          e = sb.pop_front();
          n_out++;
          chk("soma", 32'(soma), 32'(e.soma));
          chk("f", 32'(f), 32'(e.f));
          chk("cout", 32'(cout), 32'(e.cout));
          $display("out #%0d: soma=%h f=%b cout=%b", n_out, soma, f, cout);
        end
      end
    end
  end

  // Present operands (called at posedge+1), wait for acceptance, return just
  // after the accepting edge with inputs scrambled.
  task automatic issue(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_b,
                       input logic tsub, input logic tsat,
                       input logic [WIDTH-1:0] es, input logic ef, input logic ec,
                       input bit push);
    exp_t e;
    int   n;
    a = ta; b = tb_b; sub = tsub; sat = tsat; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready) chk("accept_timeout", 32'(in_ready), 32'd1);
    if (push) begin
      e.soma = es; e.f = ef; e.cout = ec;
      sb.push_back(e);
    end
    $display("in: a=%h b=%h sub=%b sat=%b -> expect soma=%h f=%b cout=%b",
             ta, tb_b, tsub, tsat, es, ef, ec);
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 16'hA5A5; b = 16'h5A5A; sub = ~tsub; sat = ~tsat;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (!(in_ready && sb.size() == 0) && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 100) chk("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int n;
    checks = 0; errors = 0; n_out = 0;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; sat = 1'b0;
    out_ready = 1'b1;

    // Reset state
    #3;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_soma", 32'(soma), 32'd0);
    chk("rst_f", 32'(f), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_in_ready", 32'(in_ready), 32'd1);

    // Overflow, wrap, with latency check
    issue(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b1, 1'b0, 1'b1);
    for (int k = 1; k <= NCHUNK; k++) begin
      chk("busy_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      chk("latency_out_valid", 32'(out_valid), (k == NCHUNK) ? 32'd1 : 32'd0);
    end
    wait_drain();

    // Overflow, saturate
    issue(16'h7FFF, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b0, 1'b1);
    wait_drain();
    // Subtract, saturate
    issue(16'h8000, 16'h0001, 1'b1, 1'b1, 16'h8000, 1'b1, 1'b1, 1'b1);
    wait_drain();
    // Subtract, no saturation requested: raw result
    issue(16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b1);
    wait_drain();
    // Unsigned wrap
    issue(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1);
    wait_drain();
    // Subtract with borrow, no overflow, sat has no effect
    issue(16'h1000, 16'h2000, 1'b1, 1'b1, 16'hF000, 1'b0, 1'b0, 1'b1);
    wait_drain();

    // Backpressure
    out_ready = 1'b0;
    issue(16'h0003, 16'h0005, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0, 1'b1);
    n = 0;
    while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
    chk("bp_out_valid", 32'(out_valid), 32'd1);
    in_valid = 1'b1; a = 16'h7FFF; b = 16'h7FFF; sub = 1'b0; sat = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("bp_soma", 32'(soma), 32'hFFFE);
      chk("bp_f", 32'(f), 32'd0);
      chk("bp_cout", 32'(cout), 32'd0);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_idle", 32'(in_ready), 32'd1);
    chk("bp_release_valid", 32'(out_valid), 32'd0);
    issue(16'h0100, 16'h0023, 1'b0, 1'b0, 16'h0123, 1'b0, 1'b0, 1'b1);
    wait_drain();

    // Reset mid-CALC after two chunks
    issue(16'h7FFF, 16'h7FFF, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_soma", 32'(soma), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    issue(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b1);
    wait_drain();

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    chk("outputs_seen", 32'(n_out), 32'd9);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
